// File: rtl/mod_n_counter.sv
// mod_n_counter: synchronous cascaded modulo-N counter with count enable,
// parallel load, a combinational terminal count and a registered wrap pulse.
// All digits share one clock, so there is no ripple delay between digits.
// Optional feature macro: MOD_N_CNT_DOWN_EN adds the dn port and down counting.
//
// Ports:
//   clk  in   1            rising-edge clock
//   clr  in   1            synchronous active-high reset
//   en   in   1            count enable
//   ld   in   1            synchronous parallel load (wins over en)
//   din  in   DIGITS*W     load value, digit i at din[i*W +: W]
//   dn   in   1            count direction, 1 = down (MOD_N_CNT_DOWN_EN only)
//   q    out  DIGITS*W     count value, digit 0 in the LSBs
//   tc   out  1            terminal count, combinational from q/en/dn
//   ovf  out  1            one-cycle pulse when q shows the fully wrapped value
module mod_n_counter #(
  parameter int unsigned MOD    = 10,
  parameter int unsigned DIGITS = 2,
  localparam int unsigned W     = $clog2(MOD)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                ld,
  input  logic [DIGITS*W-1:0] din,
`ifdef MOD_N_CNT_DOWN_EN
  input  logic                dn,
`endif
  output logic [DIGITS*W-1:0] q,
  output logic                tc,
  output logic                ovf
);

  // Largest legal digit value; compared explicitly so a power-of-two MOD
  // never relies on natural binary overflow.
  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  logic [DIGITS*W-1:0] q_nxt;
  logic                ovf_nxt;
  logic [DIGITS:0]     up_chain;
  logic [W-1:0]        cur;
  logic [W-1:0]        ldd;
  logic                wrap_c;
`ifdef MOD_N_CNT_DOWN_EN
  logic [DIGITS:0]     dn_chain;
`endif

  // Carry/borrow chains: chain[i] is set when all digits below i are at the
  // boundary, i.e. digit i steps on an enabled edge.
  always_comb begin
    up_chain[0] = 1'b1;
`ifdef MOD_N_CNT_DOWN_EN
    dn_chain[0] = 1'b1;
`endif
    for (int i = 0; i < int'(DIGITS); i++) begin
      up_chain[i+1] = up_chain[i] & (q[i*W +: W] == MAXV);
`ifdef MOD_N_CNT_DOWN_EN
      dn_chain[i+1] = dn_chain[i] & (q[i*W +: W] == '0);
`endif
    end
`ifdef MOD_N_CNT_DOWN_EN
    wrap_c = dn ? dn_chain[DIGITS] : up_chain[DIGITS];
`else
    wrap_c = up_chain[DIGITS];
`endif
  end

  assign tc = en & wrap_c;

  // Next-state: load (clamped per digit) beats count; hold otherwise.
  always_comb begin
    q_nxt   = q;
    ovf_nxt = 1'b0;
    cur     = '0;
    ldd     = '0;
    if (ld) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        ldd = din[i*W +: W];
        q_nxt[i*W +: W] = (ldd > MAXV) ? '0 : ldd;
      end
    end else if (en) begin
      ovf_nxt = wrap_c;
      for (int i = 0; i < int'(DIGITS); i++) begin
        cur = q[i*W +: W];
`ifdef MOD_N_CNT_DOWN_EN
        if (dn) begin
          if (dn_chain[i]) begin
            q_nxt[i*W +: W] = (cur == '0) ? MAXV : cur - W'(1);
          end
        end else if (up_chain[i]) begin
          q_nxt[i*W +: W] = (cur >= MAXV) ? '0 : cur + W'(1);
        end
`else
        if (up_chain[i]) begin
          q_nxt[i*W +: W] = (cur >= MAXV) ? '0 : cur + W'(1);
        end
`endif
      end
    end
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

  localparam int unsigned MOD    = 10;
  localparam int unsigned DIGITS = 2;
  localparam int unsigned QW     = 8;

  typedef struct {
    logic [QW-1:0] q;
    logic          ovf;
    logic          tc;
    string         name;
  } exp_t;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          en  = 1'b0;
  logic          ld  = 1'b0;
  logic          dn  = 1'b0;
  logic [QW-1:0] din = '0;
  logic [QW-1:0] q;
  logic          tc;
  logic          ovf;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  mod_n_counter #(.MOD(MOD), .DIGITS(DIGITS)) dut (
    .clk(clk),
    .clr(clr),
    .en (en),
    .ld (ld),
    .din(din),
`ifdef MOD_N_CNT_DOWN_EN
    .dn (dn),
`endif
    .q  (q),
    .tc (tc),
    .ovf(ovf)
  );

  function automatic logic [QW-1:0] bcd(input int v);
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic step(input logic c, input logic l, input logic e, input logic d,
                      input logic [QW-1:0] di, input logic [QW-1:0] eq,
                      input logic eovf, input logic etc, input string nm);
    exp_t x;
    @(negedge clk);
    clr = c; ld = l; en = e; dn = d; din = di;
    x.q = eq; x.ovf = eovf; x.tc = etc; x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: after every active edge, compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (q !== x.q) begin
        fails++;
        $display("FAIL %s q: got %h expected %h", x.name, q, x.q);
      end
      checks++;
      if (ovf !== x.ovf) begin
        fails++;
        $display("FAIL %s ovf: got %b expected %b (q=%h)", x.name, ovf, x.ovf, q);
      end
      checks++;
      if (tc !== x.tc) begin
        fails++;
        $display("FAIL %s tc: got %b expected %b (q=%h)", x.name, tc, x.tc, q);
      end
    end
  end

  initial begin
    // Reset, then 100 enabled cycles: 00..99 and back to 00 with one ovf.
    step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, "reset");
    for (int k = 1; k <= 100; k++)
      step(0, 0, 1, 0, 8'h00, bcd(k % 100), (k == 100), ((k % 100) == 99), "count_up");

    // Enable gating from 37.
    step(0, 1, 0, 0, 8'h37, 8'h37, 0, 0, "load_37");
    step(0, 0, 1, 0, 8'h00, 8'h38, 0, 0, "en_1");
    step(0, 0, 0, 0, 8'h00, 8'h38, 0, 0, "en_0a");
    step(0, 0, 0, 0, 8'h00, 8'h38, 0, 0, "en_0b");
    step(0, 0, 1, 0, 8'h00, 8'h39, 0, 0, "en_1b");

    // Loads, including out-of-range digits clamped to 0.
    step(0, 1, 0, 0, 8'h47, 8'h47, 0, 0, "load_47");
    step(0, 1, 0, 0, 8'h4C, 8'h40, 0, 0, "load_4C");
    step(0, 1, 0, 0, 8'hCC, 8'h00, 0, 0, "load_CC");
    step(0, 1, 0, 0, 8'hA9, 8'h09, 0, 0, "load_A9");

    // clr beats ld and en; then ld beats en.
    step(0, 1, 0, 0, 8'h57, 8'h57, 0, 0, "load_57");
    step(1, 1, 1, 0, 8'h88, 8'h00, 0, 0, "clr_all");
    step(0, 1, 1, 0, 8'h12, 8'h12, 0, 0, "ld_en_12");

    // Load at 99 with en: no count, tc live; hold; then wrap with ovf.
    step(0, 1, 1, 0, 8'h99, 8'h99, 0, 1, "ld_en_99");
    step(0, 0, 0, 0, 8'h00, 8'h99, 0, 0, "hold_99");
    step(0, 0, 1, 0, 8'h00, 8'h00, 1, 0, "wrap_99");
    step(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, "after_wrap");
    step(0, 0, 0, 0, 8'h00, 8'h01, 0, 0, "idle_01");

`ifdef MOD_N_CNT_DOWN_EN
    // Down counting through the full wrap, then back up.
    step(0, 1, 0, 1, 8'h01, 8'h01, 0, 0, "dn_load_01");
    step(0, 0, 1, 1, 8'h00, 8'h00, 0, 1, "dn_to_00");
    step(0, 0, 1, 1, 8'h00, 8'h99, 1, 0, "dn_wrap");
    step(0, 0, 1, 0, 8'h00, 8'h00, 1, 0, "up_wrap");
    step(0, 0, 1, 1, 8'h00, 8'h99, 1, 0, "dn_wrap2");
    step(0, 0, 1, 1, 8'h00, 8'h98, 0, 0, "dn_98");
    step(0, 1, 1, 1, 8'h30, 8'h30, 0, 0, "dn_ld_30");
    step(0, 0, 1, 1, 8'h00, 8'h29, 0, 0, "dn_borrow");
    step(1, 0, 1, 1, 8'h00, 8'h00, 0, 1, "dn_reset_tc");
    step(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, "dn_idle");
`endif

    @(negedge clk);
    clr = 0; ld = 0; en = 0; dn = 0; din = '0;
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
